// File: rtl/pipelined_approx_adder_if.sv
// Operand/result stream bundle for pipelined_approx_adder.
// The master side produces operands and consumes results; the slave side is the adder.
interface pipelined_approx_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_approx;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic             out_approx;

  modport master (
    output in_valid, in_a, in_b, in_approx, out_ready,
    input  in_ready, out_valid, out_sum, out_approx
  );

  modport slave (
    input  in_valid, in_a, in_b, in_approx, out_ready,
    output in_ready, out_valid, out_sum, out_approx
  );
endinterface

// File: rtl/pipelined_approx_adder.sv
// Pipelined adder, one SEG-bit carry-lookahead segment per register stage,
// with a runtime lower-part-OR approximation over the APPROX_BITS LSBs.
// Optional on-line error counter: define PIPELINED_APPROX_ADDER_ERR_STAT_EN.
module pipelined_approx_adder #(
  parameter int WIDTH       = 16,
  parameter int SEG         = 4,
  parameter int APPROX_BITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  pipelined_approx_adder_if.slave bus
`ifdef PIPELINED_APPROX_ADDER_ERR_STAT_EN
  ,
  input  logic        err_clr,
  output logic [31:0] err_cnt
`endif
);

  localparam int NSEG = WIDTH / SEG;

  // Whole pipeline moves as one: a bubble is never squashed under stall.
  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic             vld_in, apx_in, c_in;
    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic             vld_q, apx_q, c_q, c_d;
    logic [WIDTH-1:0] a_q, b_q, s_q, s_d;
`ifdef PIPELINED_APPROX_ADDER_ERR_STAT_EN
    logic             ec_in, ec_q, ec_d;
    logic [WIDTH-1:0] es_in, es_q, es_d;
`endif

    if (k == 0) begin : g_head
      assign vld_in = bus.in_valid;
      assign apx_in = bus.in_approx;
      assign a_in   = bus.in_a;
      assign b_in   = bus.in_b;
      assign s_in   = '0;
      assign c_in   = 1'b0;
`ifdef PIPELINED_APPROX_ADDER_ERR_STAT_EN
      assign es_in  = '0;
      assign ec_in  = 1'b0;
`endif
    end else begin : g_body
      assign vld_in = g_stage[k-1].vld_q;
      assign apx_in = g_stage[k-1].apx_q;
      assign a_in   = g_stage[k-1].a_q;
      assign b_in   = g_stage[k-1].b_q;
      assign s_in   = g_stage[k-1].s_q;
      assign c_in   = g_stage[k-1].c_q;
`ifdef PIPELINED_APPROX_ADDER_ERR_STAT_EN
      assign es_in  = g_stage[k-1].es_q;
      assign ec_in  = g_stage[k-1].ec_q;
`endif
    end

    // Segment k: per-bit generate/propagate, OR-ed bits in the approximated region.
    // Inside that region the carry is just G, so bit APPROX_BITS sees a&b of the top approx bit.
    always_comb begin
      s_d = s_in;
      c_d = c_in;
`ifdef PIPELINED_APPROX_ADDER_ERR_STAT_EN
      es_d = es_in;
      ec_d = ec_in;
`endif
      for (int j = 0; j < SEG; j++) begin
        if (apx_in && (k * SEG + j < APPROX_BITS)) begin
          s_d[k*SEG+j] = a_in[k*SEG+j] | b_in[k*SEG+j];
          c_d          = a_in[k*SEG+j] & b_in[k*SEG+j];
        end else begin
          s_d[k*SEG+j] = a_in[k*SEG+j] ^ b_in[k*SEG+j] ^ c_d;
          c_d          = (a_in[k*SEG+j] & b_in[k*SEG+j]) |
                         ((a_in[k*SEG+j] | b_in[k*SEG+j]) & c_d);
        end
`ifdef PIPELINED_APPROX_ADDER_ERR_STAT_EN
        es_d[k*SEG+j] = a_in[k*SEG+j] ^ b_in[k*SEG+j] ^ ec_d;
        ec_d          = (a_in[k*SEG+j] & b_in[k*SEG+j]) |
                        ((a_in[k*SEG+j] | b_in[k*SEG+j]) & ec_d);
`endif
      end
    end

    // Stage register with skew: operands ride along for later segments.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        apx_q <= 1'b0;
        a_q   <= '0;
        b_q   <= '0;
        s_q   <= '0;
        c_q   <= 1'b0;
`ifdef PIPELINED_APPROX_ADDER_ERR_STAT_EN
        es_q  <= '0;
        ec_q  <= 1'b0;
`endif
      end else if (adv) begin
        vld_q <= vld_in;
        apx_q <= apx_in;
        a_q   <= a_in;
        b_q   <= b_in;
        s_q   <= s_d;
        c_q   <= c_d;
`ifdef PIPELINED_APPROX_ADDER_ERR_STAT_EN
        es_q  <= es_d;
        ec_q  <= ec_d;
`endif
      end
    end

    // Already-consumed operand bits are carried but never read again.
    logic unused_skew;
    assign unused_skew = ^{a_q, b_q, a_in, b_in};
  end

  assign bus.out_valid  = g_stage[NSEG-1].vld_q;
  assign bus.out_approx = g_stage[NSEG-1].apx_q;
  assign bus.out_sum    = {g_stage[NSEG-1].c_q, g_stage[NSEG-1].s_q};

`ifdef PIPELINED_APPROX_ADDER_ERR_STAT_EN
  logic [31:0] err_cnt_q;
  logic        xfer, mism;
  assign xfer = bus.out_valid && bus.out_ready;
  assign mism = bus.out_sum != {g_stage[NSEG-1].ec_q, g_stage[NSEG-1].es_q};

  // Saturating count of delivered results that differ from the exact sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_clr) begin
      err_cnt_q <= '0;
    end else if (xfer && mism && (err_cnt_q != 32'hFFFF_FFFF)) begin
      err_cnt_q <= err_cnt_q + 32'd1;
    end
  end
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_pipelined_approx_adder.sv
// Self-checking bench for pipelined_approx_adder (WIDTH=16, SEG=4, APPROX_BITS=4).
module tb_pipelined_approx_adder;
  localparam int W    = 16;
  localparam int AB   = 4;
  localparam int NSEG = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_approx_adder_if #(.WIDTH(W)) bus ();

`ifdef PIPELINED_APPROX_ADDER_ERR_STAT_EN
  logic        err_clr;
  logic [31:0] err_cnt;
  logic [31:0] model_err;
`endif

  pipelined_approx_adder #(.WIDTH(W), .SEG(4), .APPROX_BITS(AB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PIPELINED_APPROX_ADDER_ERR_STAT_EN
    ,
    .err_clr (err_clr),
    .err_cnt (err_cnt)
`endif
  );

  typedef struct {
    logic [W:0] sum;
    logic       apx;
    logic [W:0] exact;
    int         acc;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  int         n_pass = 0;
  int         n_total = 0;
  int         cyc = 0;
  int         n_xfer = 0;
  bit         lat_chk = 0;
  bit         hold_v = 0;
  logic [W:0] hold_sum;
  logic       hold_apx;
  logic [W:0] last_sum;
  bit         rnd_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference: low part OR-ed, carry from the top approx bit, exact above.
  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic apx);
    int unsigned lo, hi, m;
    if (apx && AB > 0) begin
      m  = (32'd1 << AB) - 32'd1;
      lo = (32'(a) | 32'(b)) & m;
      hi = (32'(a) >> AB) + (32'(b) >> AB) + 32'(a[AB-1] & b[AB-1]);
      return (W+1)'((hi << AB) | lo);
    end
    return (W+1)'(32'(a) + 32'(b));
  endfunction

  // Compare process: sampled on the falling edge, describing the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hold_v = 0;
`ifdef PIPELINED_APPROX_ADDER_ERR_STAT_EN
      model_err = '0;
`endif
    end else begin
      if (bus.in_valid && bus.in_ready)
        q.push_back('{model_sum(bus.in_a, bus.in_b, bus.in_approx), bus.in_approx,
                      (W+1)'(32'(bus.in_a) + 32'(bus.in_b)), cyc + 1});
      chk("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (hold_v) begin
        chk("stall_valid", bus.out_valid, 1'b1);
        chk("stall_sum", bus.out_sum, hold_sum);
        chk("stall_apx", bus.out_approx, hold_apx);
      end
`ifdef PIPELINED_APPROX_ADDER_ERR_STAT_EN
      chk("err_cnt", err_cnt, model_err);
      if (err_clr) model_err = '0;
`endif
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", bus.out_sum, '1);
        end else begin
          e = q.pop_front();
          chk("out_sum", bus.out_sum, e.sum);
          chk("out_apx", bus.out_approx, e.apx);
          if (lat_chk) chk("latency", cyc, e.acc + NSEG - 1);
`ifdef PIPELINED_APPROX_ADDER_ERR_STAT_EN
          if (!err_clr && e.sum != e.exact && model_err != 32'hFFFF_FFFF)
            model_err = model_err + 1;
`endif
        end
        last_sum = bus.out_sum;
        n_xfer++;
      end
      hold_v   = bus.out_valid && !bus.out_ready;
      hold_sum = bus.out_sum;
      hold_apx = bus.out_approx;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic apx);
    int n = 0;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_approx = apx;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && !bus.out_valid) break;
      n++;
      if (n > 300) begin
        chk("drain_timeout", q.size(), 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_approx = 1'b0;
    bus.out_ready = 1'b0;
`ifdef PIPELINED_APPROX_ADDER_ERR_STAT_EN
    err_clr   = 1'b0;
    model_err = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_out_apx", bus.out_approx, 0);
    rst_n = 1'b1;
    chk("rst_in_ready", bus.in_ready, 1);

    // model pins
    chk("model_loa_f1", model_sum(16'h000F, 16'h0001, 1'b1), 17'h0000F);
    chk("model_loa_88", model_sum(16'h0008, 16'h0008, 1'b1), 17'h00018);

    // exact with latency checking
    bus.out_ready = 1'b1;
    lat_chk = 1;
    send(16'hFFFF, 16'h0001, 1'b0); drain(); chk("ripple", last_sum, 17'h10000);
    send(16'h1234, 16'h4321, 1'b0); drain(); chk("exact_5555", last_sum, 17'h05555);
    send(16'h000F, 16'h0001, 1'b1); drain(); chk("loa_f1", last_sum, 17'h0000F);
    send(16'h0008, 16'h0008, 1'b1); drain(); chk("loa_88", last_sum, 17'h00018);
    send(16'h0008, 16'h0008, 1'b0); drain(); chk("exact_88", last_sum, 17'h00010);

    // back-to-back stream
    x0 = n_xfer;
    for (int i = 0; i < 8; i++) send(16'(i), 16'h00FF, 1'b0);
    drain();
    chk("stream_count", n_xfer - x0, 8);
    chk("stream_last", last_sum, 17'h00106);
    lat_chk = 0;

    // backpressure mid-stream
    x0 = n_xfer;
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'(16'h0100 * i + i), 16'h0F0F, 1'(i & 1));
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", n_xfer - x0, 6);

    // reset with beats in flight
    send(16'h0005, 16'h0001, 1'b0);
    send(16'h0006, 16'h0001, 1'b0);
    send(16'h0007, 16'h0001, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_sum", bus.out_sum, 0);
    rst_n = 1'b1;
    send(16'h0002, 16'h0003, 1'b0); drain(); chk("post_rst", last_sum, 17'h00005);

`ifdef PIPELINED_APPROX_ADDER_ERR_STAT_EN
    send(16'h000F, 16'h0001, 1'b1);
    send(16'h0008, 16'h0008, 1'b1);
    send(16'h0008, 16'h0008, 1'b0);
    drain();
    chk("err_two", err_cnt, 32'd2);
    bus.out_ready = 1'b0;
    send(16'h000F, 16'h0001, 1'b1);
    begin
      int n = 0;
      while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
      chk("err_wait_valid", bus.out_valid, 1);
    end
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("err_clr_prio", err_cnt, 32'd0);
    force dut.err_cnt_q = 32'hFFFF_FFFF;
    model_err = 32'hFFFF_FFFF;
    #1;
    release dut.err_cnt_q;
    send(16'h000F, 16'h0001, 1'b1); drain();
    chk("err_sat", err_cnt, 32'hFFFF_FFFF);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
`endif

    // randomized traffic with random backpressure
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [W-1:0] a, b;
          a = 16'($urandom_range(0, 65535));
          b = 16'($urandom_range(0, 65535));
          if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
          if ($urandom_range(0, 7) == 0) b = 16'($urandom_range(0, 15));
          send(a, b, 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("rnd_queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipelined_approx_adder.md
Name: pipelined_approx_adder

Overview:
- Parametrised successor to the 2-bit carry-lookahead adder, generalised to WIDTH bits.
- Carry chain is split into SEG-bit carry-lookahead segments, one segment per pipeline stage.
- Runtime-selectable lower-part-OR (LOA) approximation on the APPROX_BITS LSBs.
- Valid/ready stream on input and output; serves as the datapath adder for approximate-computing experiments, with optional on-line error statistics.

Parameters:
- WIDTH, 16, operand width; must be a multiple of SEG.
- SEG, 4, bits per CLA segment and pipeline stage; NSEG = WIDTH/SEG (at least 1).
- APPROX_BITS, 4, LSBs approximated in approx mode; range 0..WIDTH-1; 0 means approx mode equals exact.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_approx  in  1  1 = LOA approximate mode, 0 = exact; sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  WIDTH+1  sum; MSB is the carry out.
- out_approx  out  1  mode tag travelling with the result.

Behaviour:
- Reset: rst_n low at a rising clk clears all stage valid flags, out_valid, out_sum and out_approx to 0. in_ready is 1 in the first cycle after reset release.
- Reset mid-operation: all in-flight beats are discarded; no stale result ever appears on the output.
- Pipeline: NSEG register stages; stage k (0..NSEG-1) computes segment k from the registered carry of stage k-1 (carry into stage 0 = 0).
- Each stage uses generate/propagate CLA per bit: G = a&b, P = a|b, c[i+1] = G|P&c[i], s = a^b^c.
- Unprocessed high segments and already-computed low sum bits are carried forward in skew registers.
- Latency: a beat accepted at edge t is presented with out_valid = 1 after edge t+NSEG-1, i.e. NSEG edges including the accept edge. Throughput is one beat per cycle.
- Approx mode (tag = 1, APPROX_BITS > 0):
  - sum[APPROX_BITS-1:0] = a|b over those bits.
  - Carry into bit APPROX_BITS = a[APPROX_BITS-1] & b[APPROX_BITS-1].
  - Bits above APPROX_BITS are exact. An approximated region may span several segments.
- Exact mode: out_sum = in_a + in_b, zero-extended to WIDTH+1 bits, unsigned.
- Handshake:
  - adv = !out_valid | out_ready; all stages shift when adv = 1 and hold when adv = 0.
  - in_ready = adv, combinational. A beat transfers when in_valid & in_ready.
  - Bubbles propagate as valid = 0 stages. A bubble stage is not squashed while the output is stalled, so occupancy never exceeds NSEG.
- Output transfer occurs on out_valid & out_ready. out_sum and out_approx stay stable while out_valid = 1 and out_ready = 0.
- Simultaneous input accept and output transfer in the same cycle is legal and loses no data.
- Result order equals input order.

Optional Feature:
- Macro: PIPELINED_APPROX_ADDER_ERR_STAT_EN.
- Defined:
  - Adds a shadow exact sum, computed through the same pipeline, plus ports err_clr (in, 1) and err_cnt (out, 32).
  - err_cnt increments on each output transfer whose out_sum differs from the exact sum.
  - err_cnt saturates at 0xFFFFFFFF and is cleared by reset or err_clr = 1.
  - err_clr takes priority over a simultaneous increment.
- Undefined: the shadow path, err_clr and err_cnt do not exist; behaviour is otherwise identical.

Test Plan:
(All scenarios use WIDTH=16, SEG=4, APPROX_BITS=4, so NSEG=4.)
- Exact carry ripple: a=0xFFFF, b=0x0001, approx=0, out_ready=1 -> out_sum=0x10000 with out_valid first high 4 edges after accept; a=0x1234, b=0x4321 -> 0x05555.
- Approx LOA: a=0x000F, b=0x0001, approx=1 -> out_sum=0x0000F (exact 0x00010); a=0x0008, b=0x0008, approx=1 -> 0x00018; same operands with approx=0 -> 0x00010.
- Streaming: 8 back-to-back beats a=i, b=0x00FF (i=0..7), exact -> out_valid high 8 consecutive cycles starting at latency 4, sums 0x00FF..0x0106 in order.
- Backpressure: 6 beats streamed, out_ready low for 3 cycles mid-stream -> in_ready low while out_valid=1 and out_ready=0, out_sum held stable, all 6 results delivered in order with none lost or duplicated.
- Reset mid-operation: 3 beats in flight, rst_n low one edge -> out_valid=0 and out_sum=0 after that edge, no old result emitted, and a new beat a=2, b=3 returns 0x00005.
- ERR_STAT (macro defined): the two approx beats of scenario 2 plus one exact beat -> err_cnt=2. Pulsing err_clr in the same cycle as a mismatching transfer -> err_cnt=0. Preloading the counter near max by forcing 0xFFFFFFFF then a mismatch -> stays 0xFFFFFFFF.
